soc_system_sysid_checker: RTL and testbench

- Avalon-MM master that reads the two-word system-ID slave (word 0 = ID, word 1 = build timestamp) after a start pulse.
- Captures both words, compares them against expected values and reports pass/fail with per-field flags.
- Sits beside the HPS bridge on the Qsys fabric as a hardware self-check before the CNN accelerator is enabled.

---
 rtl/soc_system_sysid_pkg.sv | 26 ++
 rtl/soc_system_sysid_rd_timer.sv | 27 ++
 rtl/soc_system_sysid_checker.sv | 179 +++++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_sysid_pkg.sv
// Shared state encoding, slave word addresses and default expected values
// for the system-ID self-check master.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'hACD51302;
  localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'h55925416;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // True in every state where a read is outstanding and the timeout applies.
  function automatic logic in_read_phase(input sysid_state_e s);
    return (s == RD_ID) || (s == WAIT_ID) || (s == RD_TS) || (s == WAIT_TS);
  endfunction

endpackage

// File: rtl/soc_system_sysid_rd_timer.sv
// 8-bit per-read timeout counter; cleared when a read phase begins, expires
// on the last allowed cycle so the master can abandon the read.
module soc_system_sysid_rd_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of cycles already spent, so the current cycle is the last one
  assign expired = enable && (count == limit - 8'd1);

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID, then timestamp) and reports
// pass/fail. Define SYSID_CHECKER_TS_CHECK_EN to make ts_ok compare the timestamp.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

`ifdef SYSID_CHECKER_TS_CHECK_EN
  localparam logic TS_STRICT = 1'b1;
`else
  localparam logic TS_STRICT = 1'b0;
`endif

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  sysid_state_e state;
  logic         id_got;
  logic         ts_got;
  logic         timer_clear;
  logic         timer_enable;
  logic         expired;
  logic         id_match;
  logic         ts_match;

  // A word that never arrived must not count as a match, even if the expected value is 0.
  assign id_match     = id_got && (id_value == EXPECTED_ID);
  assign ts_match     = ts_got && (!TS_STRICT || (ts_value == EXPECTED_TS));
  assign timer_enable = in_read_phase(state);

  always_comb begin
    timer_clear = 1'b0;
    case (state)
      IDLE:    timer_clear = start;
      RD_ID:   timer_clear = !avm_waitrequest && avm_readdatavalid;
      WAIT_ID: timer_clear = avm_readdatavalid;
      default: timer_clear = 1'b0;
    endcase
  end

  soc_system_sysid_rd_timer u_rd_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (TIMEOUT_LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      id_got      <= 1'b0;
      ts_got      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            id_got      <= 1'b0;
            ts_got      <= 1'b0;
          end
        end

        // A zero-latency slave returns data in the accept cycle, so capture wins over expiry.
        RD_ID: begin
          if (!avm_waitrequest && avm_readdatavalid) begin
            id_value    <= avm_readdata;
            id_got      <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
            state       <= RD_TS;
          end else if (expired) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            state    <= FINISH;
          end else if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= WAIT_ID;
          end
        end

        WAIT_ID: begin
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            id_got      <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
            state       <= RD_TS;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end
        end

        RD_TS: begin
          if (!avm_waitrequest && avm_readdatavalid) begin
            ts_value <= avm_readdata;
            ts_got   <= 1'b1;
            avm_read <= 1'b0;
            state    <= FINISH;
          end else if (expired) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            state    <= FINISH;
          end else if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= WAIT_TS;
          end
        end

        WAIT_TS: begin
          if (avm_readdatavalid) begin
            ts_value <= avm_readdata;
            ts_got   <= 1'b1;
            state    <= FINISH;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= FINISH;
          end
        end

        FINISH: begin
          id_ok <= id_match;
          ts_ok <= ts_match && !timeout;
          pass  <= id_match && ts_match && !timeout;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed self-checking bench for soc_system_sysid_checker with a configurable
// sysid slave model (wait states, read latency, dropped timestamp response).
`timescale 1ns/1ps
module tb_soc_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;

  logic [31:0] cfg_id;
  logic [31:0] cfg_ts;
  int          cfg_wait;
  int          cfg_lat;
  logic        cfg_drop_ts;
  logic        slave_clear;
  logic        mon_clear;

  int   stall_cnt;
  int   lat_cnt;
  logic pend;
  logic pend_addr;
  int   accepts;
  int   stall_viol;
  logic prev_stall;
  logic prev_addr;

  always #5 clock = ~clock;

  soc_system_sysid_checker dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  // Slave model: stalls cfg_wait cycles per read, answers cfg_lat cycles after accept.
  always_comb begin
    avm_waitrequest   = avm_read && (stall_cnt < cfg_wait);
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    if (pend && lat_cnt == 0) begin
      avm_readdatavalid = !(pend_addr && cfg_drop_ts);
      avm_readdata      = pend_addr ? cfg_ts : cfg_id;
    end else if (avm_read && !avm_waitrequest && cfg_lat == 0) begin
      avm_readdatavalid = !(avm_address && cfg_drop_ts);
      avm_readdata      = avm_address ? cfg_ts : cfg_id;
    end
  end

  always @(posedge clock) begin
    if (slave_clear) begin
      stall_cnt <= 0;
      lat_cnt   <= 0;
      pend      <= 1'b0;
      pend_addr <= 1'b0;
    end else begin
      if (avm_read && avm_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      if (pend) begin
        if (lat_cnt == 0) pend <= 1'b0;
        else lat_cnt <= lat_cnt - 1;
      end
      if (avm_read && !avm_waitrequest && cfg_lat > 0) begin
        pend      <= 1'b1;
        lat_cnt   <= cfg_lat - 1;
        pend_addr <= avm_address;
      end
    end
  end

  // Bus monitor: counts accepted reads and any change of read/address during a stall.
  always @(posedge clock) begin
    if (mon_clear) begin
      accepts    <= 0;
      stall_viol <= 0;
      prev_stall <= 1'b0;
      prev_addr  <= 1'b0;
    end else begin
      if (reset_n && prev_stall && !(avm_read && avm_address == prev_addr))
        stall_viol <= stall_viol + 1;
      prev_stall <= avm_read && avm_waitrequest;
      prev_addr  <= avm_address;
      if (avm_read && !avm_waitrequest) accepts <= accepts + 1;
    end
  end

  task automatic set_slave(input logic [31:0] id, input logic [31:0] ts,
                           input int wait_cycles, input int lat, input logic drop_ts);
    cfg_id      = id;
    cfg_ts      = ts;
    cfg_wait    = wait_cycles;
    cfg_lat     = lat;
    cfg_drop_ts = drop_ts;
  endtask

  task automatic clear_monitors();
    @(negedge clock);
    slave_clear = 1'b1;
    mon_clear   = 1'b1;
    @(negedge clock);
    slave_clear = 1'b0;
    mon_clear   = 1'b0;
  endtask

  // Pulses start for the edge counted as 1, then counts edges until done is seen.
  task automatic run_seq(input int max_edges, output int edges);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    start = 1'b0;
    while (!done && edges < max_edges) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000000",
               {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if ({id_value, ts_value} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h %h expected 0 0", id_value, ts_value);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    int edges;
    set_slave(32'hACD51302, 32'h55925416, 0, 0, 1'b0);
    clear_monitors();
    run_seq(20, edges);
    checks++;
    if (edges !== 4) begin
      errors++;
      $display("[TB] FAIL zero_wait_latency: got %0d edges expected 4", edges);
    end
    checks++;
    if ({done, busy, pass, id_ok, ts_ok, timeout} !== 6'b101110) begin
      errors++;
      $display("[TB] FAIL zero_wait_flags: got %b expected 101110",
               {done, busy, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if (id_value !== 32'hACD51302 || ts_value !== 32'h55925416) begin
      errors++;
      $display("[TB] FAIL zero_wait_values: got %h %h expected acd51302 55925416",
               id_value, ts_value);
    end
    checks++;
    if (accepts !== 2) begin
      errors++;
      $display("[TB] FAIL zero_wait_reads: got %0d expected 2", accepts);
    end
  endtask

  task automatic test_bad_id();
    int edges;
    set_slave(32'h00000001, 32'h55925416, 0, 0, 1'b0);
    clear_monitors();
    run_seq(20, edges);
    checks++;
    if ({done, pass, id_ok, ts_ok, timeout} !== 5'b10010) begin
      errors++;
      $display("[TB] FAIL bad_id_flags: got %b expected 10010",
               {done, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if (id_value !== 32'h00000001) begin
      errors++;
      $display("[TB] FAIL bad_id_value: got %h expected 00000001", id_value);
    end
  endtask

  task automatic test_stall_latency();
    int edges;
    set_slave(32'hACD51302, 32'h55925416, 3, 2, 1'b0);
    clear_monitors();
    run_seq(40, edges);
    checks++;
    if (edges !== 14) begin
      errors++;
      $display("[TB] FAIL stall_latency: got %0d edges expected 14", edges);
    end
    checks++;
    if ({done, pass, timeout} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL stall_flags: got %b expected 110", {done, pass, timeout});
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("[TB] FAIL stall_hold: got %0d violations expected 0", stall_viol);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (accepts !== 2) begin
      errors++;
      $display("[TB] FAIL stall_reads: got %0d expected 2", accepts);
    end
  endtask

  task automatic test_timeout();
    int edges;
    set_slave(32'hACD51302, 32'h55925416, 0, 0, 1'b1);
    clear_monitors();
    run_seq(400, edges);
    checks++;
    if (edges !== 258) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d edges expected 258", edges);
    end
    checks++;
    if ({done, busy, avm_read, pass, id_ok, ts_ok, timeout} !== 7'b1000101) begin
      errors++;
      $display("[TB] FAIL timeout_flags: got %b expected 1000101",
               {done, busy, avm_read, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if (ts_value !== 32'h0 || id_value !== 32'hACD51302) begin
      errors++;
      $display("[TB] FAIL timeout_values: got %h %h expected acd51302 00000000",
               id_value, ts_value);
    end
  endtask

  task automatic test_finish_start();
    set_slave(32'hACD51302, 32'h55925416, 0, 0, 1'b0);
    clear_monitors();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({done, busy, pass, avm_read} !== 4'b1010 || accepts !== 2) begin
      errors++;
      $display("[TB] FAIL finish_start: got %b reads %0d expected 1010 reads 2",
               {done, busy, pass, avm_read}, accepts);
    end
  endtask

  task automatic test_busy_reset();
    int edges;
    set_slave(32'hACD51302, 32'h55925416, 0, 5, 1'b0);
    clear_monitors();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    checks++;
    if ({busy, avm_read, done} !== 3'b100 || accepts !== 1) begin
      errors++;
      $display("[TB] FAIL busy_wait_id: got %b reads %0d expected 100 reads 1",
               {busy, avm_read, done}, accepts);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00 ||
        {id_value, ts_value} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %b %h %h expected 00000000 0 0",
               {avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout},
               id_value, ts_value);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if ({busy, done, avm_read} !== 3'b000 || id_value !== 32'h0) begin
      errors++;
      $display("[TB] FAIL stale_rdv: got %b %h expected 000 00000000",
               {busy, done, avm_read}, id_value);
    end
    set_slave(32'hACD51302, 32'h55925416, 0, 0, 1'b0);
    clear_monitors();
    run_seq(20, edges);
    checks++;
    if (edges !== 4 || {done, pass, timeout} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL after_reset_run: got %0d edges %b expected 4 edges 110",
               edges, {done, pass, timeout});
    end
  endtask

  task automatic test_ts_mismatch();
    int   edges;
    logic exp_ts_ok;
`ifdef SYSID_CHECKER_TS_CHECK_EN
    exp_ts_ok = 1'b0;
`else
    exp_ts_ok = 1'b1;
`endif
    set_slave(32'hACD51302, 32'hDEADBEEF, 0, 0, 1'b0);
    clear_monitors();
    run_seq(20, edges);
    checks++;
    if ({done, id_ok, ts_ok, pass} !== {1'b1, 1'b1, exp_ts_ok, exp_ts_ok}) begin
      errors++;
      $display("[TB] FAIL ts_mismatch_flags: got %b expected %b",
               {done, id_ok, ts_ok, pass}, {1'b1, 1'b1, exp_ts_ok, exp_ts_ok});
    end
    checks++;
    if (ts_value !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL ts_mismatch_value: got %h expected deadbeef", ts_value);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    slave_clear = 1'b1;
    mon_clear   = 1'b1;
    set_slave(32'hACD51302, 32'h55925416, 0, 0, 1'b0);
    test_reset();
    test_zero_wait();
    test_bad_id();
    test_stall_latency();
    test_timeout();
    test_finish_start();
    test_busy_reset();
    test_ts_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
